// File: rtl/regfile_mp.sv
// Multi-port integer register file (32 x XLEN) with a per-register busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
   parameter int unsigned            XLEN     = 64,
   parameter int unsigned            NR       = 4,
   parameter int unsigned            NW       = 2,
   parameter logic [XLEN-1:0]        SP_RESET = 64'h0000003ffffffb20
) (
   input  logic                 clk_sys_i,
   input  logic                 rst_i,
   input  logic [NR*5-1:0]      rs_addr_i,
   output logic [NR*XLEN-1:0]   rs_data_o,
   output logic [NR-1:0]        rs_busy_o,
   input  logic [NW-1:0]        rd_wen_i,
   input  logic [NW*5-1:0]      rd_addr_i,
   input  logic [NW*XLEN-1:0]   rd_data_i,
   input  logic [NW-1:0]        sb_set_i,
   input  logic [NW*5-1:0]      sb_addr_i,
   input  logic                 sb_flush_i
);

   localparam int unsigned NREGS = 32;

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   // Unpacked views of the flattened write-side buses.
   logic [4:0]      wr_addr [NW];
   logic [XLEN-1:0] wr_data [NW];
   logic [NW-1:0]   wr_act;
   logic [4:0]      set_addr [NW];
   logic [NW-1:0]   set_act;

   always_comb begin
      for (int j = 0; j < NW; j++) begin
         wr_addr[j]  = rd_addr_i[j*5 +: 5];
         wr_data[j]  = rd_data_i[j*XLEN +: XLEN];
         wr_act[j]   = rd_wen_i[j] && (wr_addr[j] != 5'd0);
         set_addr[j] = sb_addr_i[j*5 +: 5];
         set_act[j]  = sb_set_i[j] && (set_addr[j] != 5'd0);
      end
   end

   // Ascending port order lets the highest-index writer win a collision.
   always_comb begin
      // NOTE: every combinational output takes a default first so no path leaves it unassigned (no latch).
      regs_d = regs_q;
      for (int j = 0; j < NW; j++) begin
         if (wr_act[j]) begin
            regs_d[wr_addr[j]] = wr_data[j];
         end
      end
   end

   // Priority low to high: hold, writeback clear, issue set, flush.
   always_comb begin
      busy_d = busy_q;
      for (int j = 0; j < NW; j++) begin
         if (wr_act[j]) begin
            busy_d[wr_addr[j]] = 1'b0;
         end
      end
      for (int j = 0; j < NW; j++) begin
         if (set_act[j]) begin
            busy_d[set_addr[j]] = 1'b1;
         end
      end
      if (sb_flush_i) begin
         busy_d = '0;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         // NOTE: the array is reset explicitly because x2 must come up as SP_RESET; it cannot map to a RAM macro.
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= (r == 2) ? SP_RESET : '0;
         end
         busy_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all registers update together at the edge.
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= regs_d[r];
         end
         busy_q <= busy_d;
      end
   end

   always_comb begin
      rs_data_o = '0;
      rs_busy_o = '0;
      for (int k = 0; k < NR; k++) begin
         logic [4:0] ra;
         ra = rs_addr_i[k*5 +: 5];
         if (ra != 5'd0) begin
            rs_data_o[k*XLEN +: XLEN] = regs_q[ra];
            rs_busy_o[k]              = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NW; j++) begin
               if (wr_act[j] && (wr_addr[j] == ra)) begin
                  rs_data_o[k*XLEN +: XLEN] = wr_data[j];
                  rs_busy_o[k]              = 1'b0;
               end
            end
            for (int j = 0; j < NW; j++) begin
               if (set_act[j] && (set_addr[j] == ra) && (wr_act != '0)) begin
                  rs_busy_o[k] = rs_busy_o[k] | (|(wr_act & {NW{1'b1}}) && bypass_hit(ra));
               end
            end
`endif
         end
      end
   end

`ifdef REGFILE_BYPASS_EN
   function automatic logic bypass_hit(input logic [4:0] a);
      logic hit;
      hit = 1'b0;
      for (int j = 0; j < NW; j++) begin
         if (wr_act[j] && (wr_addr[j] == a)) begin
            hit = 1'b1;
         end
      end
      return hit;
   endfunction
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp; expectations are hand-computed constants.
module tb_regfile_mp;

   localparam int unsigned XLEN = 64;
   localparam int unsigned NR   = 4;
   localparam int unsigned NW   = 2;
   localparam logic [XLEN-1:0] SP = 64'h0000003ffffffb20;

   logic                clk_sys_i = 1'b0;
   logic                rst_i;
   logic [NR*5-1:0]     rs_addr_i;
   logic [NR*XLEN-1:0]  rs_data_o;
   logic [NR-1:0]       rs_busy_o;
   logic [NW-1:0]       rd_wen_i;
   logic [NW*5-1:0]     rd_addr_i;
   logic [NW*XLEN-1:0]  rd_data_i;
   logic [NW-1:0]       sb_set_i;
   logic [NW*5-1:0]     sb_addr_i;
   logic                sb_flush_i;

   int checks = 0;
   int errors = 0;

   regfile_mp #(.XLEN(XLEN), .NR(NR), .NW(NW), .SP_RESET(SP)) dut (
      .clk_sys_i  (clk_sys_i),
      .rst_i      (rst_i),
      .rs_addr_i  (rs_addr_i),
      .rs_data_o  (rs_data_o),
      .rs_busy_o  (rs_busy_o),
      .rd_wen_i   (rd_wen_i),
      .rd_addr_i  (rd_addr_i),
      .rd_data_i  (rd_data_i),
      .sb_set_i   (sb_set_i),
      .sb_addr_i  (sb_addr_i),
      .sb_flush_i (sb_flush_i)
   );

   always #5 clk_sys_i = ~clk_sys_i;

   task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys_i);
      #1;
   endtask

   task automatic idle();
      rd_wen_i   = '0;
      rd_addr_i  = '0;
      rd_data_i  = '0;
      sb_set_i   = '0;
      sb_addr_i  = '0;
      sb_flush_i = 1'b0;
   endtask

   task automatic wr(input int j, input logic [4:0] a, input logic [XLEN-1:0] d);
      rd_wen_i[j]              = 1'b1;
      rd_addr_i[j*5 +: 5]      = a;
      rd_data_i[j*XLEN +: XLEN] = d;
   endtask

   task automatic sset(input int j, input logic [4:0] a);
      sb_set_i[j]         = 1'b1;
      sb_addr_i[j*5 +: 5] = a;
   endtask

   task automatic rd(input int k, input logic [4:0] a);
      rs_addr_i[k*5 +: 5] = a;
      #1;
   endtask

   function automatic logic [XLEN-1:0] dat(input int k);
      return rs_data_o[k*XLEN +: XLEN];
   endfunction

   function automatic logic [XLEN-1:0] bsy(input int k);
      return {{(XLEN-1){1'b0}}, rs_busy_o[k]};
   endfunction

   initial begin
      rst_i     = 1'b1;
      rs_addr_i = '0;
      idle();
      tick();
      tick();
      rst_i = 1'b0;

      // Reset state across all addresses on port 0
      for (int a = 0; a < 32; a++) begin
         rd(0, 5'(a));
         check($sformatf("rst_data_x%0d", a), dat(0), (a == 2) ? SP : '0);
         check($sformatf("rst_busy_x%0d", a), bsy(0), '0);
      end

      // Basic write then read on next cycle
      wr(0, 5'd5, 64'hDEADBEEF);
      rd(1, 5'd5);
`ifdef REGFILE_BYPASS_EN
      check("x5_same_cycle", dat(1), 64'hDEADBEEF);
`else
      check("x5_same_cycle", dat(1), '0);
`endif
      tick();
      idle();
      rd(1, 5'd5);
      check("x5_after_write", dat(1), 64'hDEADBEEF);

      // x0 ignores writes and scoreboard sets
      wr(1, 5'd0, 64'h1);
      sset(0, 5'd0);
      tick();
      idle();
      rd(2, 5'd0);
      check("x0_data", dat(2), '0);
      check("x0_busy", bsy(2), '0);

      // Write collision: highest port wins
      wr(0, 5'd7, 64'hA);
      wr(1, 5'd7, 64'hB);
      tick();
      idle();
      rd(3, 5'd7);
      check("x7_collision", dat(3), 64'hB);

      // Scoreboard set then write clears
      sset(0, 5'd10);
      tick();
      idle();
      rd(2, 5'd10);
      rd(3, 5'd11);
      check("x10_busy_set", bsy(2), 64'h1);
      check("x11_not_busy", bsy(3), '0);
      wr(0, 5'd10, 64'h10);
      tick();
      idle();
      rd(2, 5'd10);
      check("x10_busy_cleared", bsy(2), '0);
      check("x10_data", dat(2), 64'h10);

      // Set wins over same-cycle write clear
      sset(1, 5'd10);
      tick();
      idle();
      wr(1, 5'd10, 64'h20);
      sset(0, 5'd10);
      tick();
      idle();
      rd(2, 5'd10);
      check("x10_set_wins", bsy(2), 64'h1);
      check("x10_data2", dat(2), 64'h20);

      // Flush discards existing and same-cycle sets
      sset(0, 5'd3);
      sset(1, 5'd4);
      tick();
      idle();
      rd(0, 5'd3);
      rd(1, 5'd4);
      check("x3_busy", bsy(0), 64'h1);
      check("x4_busy", bsy(1), 64'h1);
      sb_flush_i = 1'b1;
      sset(0, 5'd6);
      tick();
      idle();
      rd(2, 5'd6);
      rd(3, 5'd10);
      check("x3_flushed", bsy(0), '0);
      check("x4_flushed", bsy(1), '0);
      check("x6_set_discarded", bsy(2), '0);
      check("x10_flushed", bsy(3), '0);

      // Duplicate set to the same register
      sset(0, 5'd9);
      sset(1, 5'd9);
      tick();
      idle();
      rd(0, 5'd9);
      check("x9_dup_set", bsy(0), 64'h1);

      // Same-cycle write and read of x12
      wr(0, 5'd12, 64'h33);
      tick();
      idle();
      wr(1, 5'd12, 64'h55);
      rd(3, 5'd12);
`ifdef REGFILE_BYPASS_EN
      check("x12_same_cycle", dat(3), 64'h55);
`else
      check("x12_same_cycle", dat(3), 64'h33);
`endif
      tick();
      idle();
      rd(3, 5'd12);
      check("x12_next_cycle", dat(3), 64'h55);

      // Reset mid-stream overrides pending writes and sets
      wr(0, 5'd12, 64'h99);
      sset(1, 5'd13);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      idle();
      rd(0, 5'd12);
      rd(1, 5'd2);
      rd(2, 5'd5);
      rd(3, 5'd13);
      check("x12_after_rst", dat(0), '0);
      check("x2_after_rst", dat(1), SP);
      check("x5_after_rst", dat(2), '0);
      check("x13_busy_after_rst", bsy(3), '0);
      rd(3, 5'd9);
      check("x9_busy_after_rst", bsy(3), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
